// File: rtl/sfu_sequencer_pkg.sv
// Shared definitions for the SFU sequencer: function-select codes, FSM states
// and the operation classes produced by the decoder.
package sfu_sequencer_pkg;

    localparam logic [4:0] FS_MUL  = 5'b11010;
    localparam logic [4:0] FS_ADC  = 5'b11011;
    localparam logic [4:0] FS_ASR  = 5'b11100;
    localparam logic [4:0] FS_BCLR = 5'b11101;
    localparam logic [4:0] FS_BSET = 5'b11110;
    localparam logic [4:0] FS_BTST = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    // BCLR and BSET share one class; the Set bit tells them apart.
    typedef enum logic [2:0] {
        OP_MUL,
        OP_ADC,
        OP_ASR,
        OP_BMOD,
        OP_BTST
    } op_e;

endpackage

// File: rtl/sfu_op_decode.sv
// Combinational function-select decoder: flags SFU codes and splits them into
// an operation class plus the Set bit used by the bit-modify class.
module sfu_op_decode
    import sfu_sequencer_pkg::*;
(
    input  logic [4:0] FS,
    output logic       is_sfu,
    output op_e        op,
    output logic       set_bit
);

    always_comb begin
        is_sfu  = 1'b1;
        op      = OP_ADC;
        set_bit = 1'b0;
        case (FS)
            FS_MUL:  op = OP_MUL;
            FS_ADC:  op = OP_ADC;
            FS_ASR:  op = OP_ASR;
            FS_BCLR: op = OP_BMOD;
            FS_BSET: begin
                op      = OP_BMOD;
                set_bit = 1'b1;
            end
            FS_BTST: op = OP_BTST;
            default: is_sfu = 1'b0;
        endcase
    end

endmodule

// File: rtl/sfu_sequencer.sv
// Multi-cycle SFU controller: single-cycle ADC/bit ops, iterative shift-add
// multiply and one-bit-per-cycle arithmetic shift right, with registered flags.
module sfu_sequencer
    import sfu_sequencer_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [4:0]   FS,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         C_in,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         C,
    output logic         Z
);

    localparam int LW = $clog2(W);

    logic            is_sfu;
    op_e             op;
    logic            set_bit;

    state_e          state;
    op_e             op_q;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    mcand;
    logic [W-1:0]    shreg;
    logic [LW-1:0]   cnt;

    logic [LW-1:0]   idx;
    logic [W:0]      adc_sum;
    logic [W-1:0]    bit_mask;
    logic [W-1:0]    bmod_res;
    logic [W:0]      hi_sum;
    logic [2*W-1:0]  prod_next;
    logic [W-1:0]    asr_next;

    sfu_op_decode u_decode (
        .FS      (FS),
        .is_sfu  (is_sfu),
        .op      (op),
        .set_bit (set_bit)
    );

    // Multiply keeps the multiplier in the low half of prod and retires one
    // bit per step by adding into the high half and shifting the whole word.
    always_comb begin
        idx       = B[LW-1:0];
        adc_sum   = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, C_in};
        bit_mask  = {{(W-1){1'b0}}, 1'b1} << idx;
        bmod_res  = set_bit ? (A | bit_mask) : (A & ~bit_mask);
        hi_sum    = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? mcand : {W{1'b0}})};
        prod_next = {hi_sum, prod[W-1:1]};
        asr_next  = {shreg[W-1], shreg[W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            op_q   <= OP_ADC;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            C      <= 1'b0;
            Z      <= 1'b0;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= '0;
            shreg  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start && is_sfu) begin
                        op_q  <= op;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        case (op)
                            OP_MUL: begin
                                prod  <= {{W{1'b0}}, B};
                                mcand <= A;
                                cnt   <= LW'(W - 1);
                                state <= ST_RUN;
                            end
                            OP_ASR: begin
                                shreg <= A;
                                if (idx == '0) begin
                                    result <= A;
                                    C      <= 1'b0;
                                    Z      <= (A == '0);
                                    done   <= 1'b1;
                                    state  <= ST_DONE;
                                end else begin
                                    cnt   <= idx - LW'(1);
                                    state <= ST_RUN;
                                end
                            end
                            OP_ADC: begin
                                result <= adc_sum[W-1:0];
                                C      <= adc_sum[W];
                                Z      <= (adc_sum[W-1:0] == '0);
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end
                            OP_BMOD: begin
                                result <= bmod_res;
                                C      <= 1'b0;
                                Z      <= (bmod_res == '0);
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end
                            default: begin
                                result <= A;
                                C      <= 1'b0;
                                Z      <= ~A[idx];
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    if (op_q == OP_MUL) begin
                        prod <= prod_next;
                        if (cnt == '0) begin
                            result <= prod_next[W-1:0];
                            C      <= |prod_next[2*W-1:W];
                            Z      <= (prod_next[W-1:0] == '0);
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            cnt <= cnt - LW'(1);
                        end
                    end else begin
                        shreg <= asr_next;
                        if (cnt == '0) begin
                            result <= asr_next;
                            C      <= shreg[0];
                            Z      <= (asr_next == '0);
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            cnt <= cnt - LW'(1);
                        end
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfu_sequencer.sv
// Scoreboard bench for sfu_sequencer: the driver pushes model results at
// accept time, the monitor pops and compares on every done pulse.
module tb_sfu_sequencer;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        z;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  FS = 5'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        C_in = 1'b0;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        C;
    logic        Z;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];

    sfu_sequencer #(.W(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .FS     (FS),
        .A      (A),
        .B      (B),
        .C_in   (C_in),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .C      (C),
        .Z      (Z)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour straight from the operation definitions.
    function automatic exp_t model(input logic [4:0] fs, input logic [15:0] a,
                                   input logic [15:0] b, input logic cin);
        exp_t        e;
        logic [31:0] p;
        logic [16:0] s;
        int          n;
        n     = int'(b[3:0]);
        e.c   = 1'b0;
        e.lat = 1;
        e.acc = 0;
        case (fs)
            5'b11010: begin
                p     = 32'(a) * 32'(b);
                e.res = p[15:0];
                e.c   = (p[31:16] != 0);
                e.lat = 17;
            end
            5'b11011: begin
                s     = 17'(a) + 17'(b) + 17'(cin);
                e.res = s[15:0];
                e.c   = s[16];
            end
            5'b11100: begin
                e.res = $signed(a) >>> n;
                e.c   = (n == 0) ? 1'b0 : a[n-1];
                e.lat = n + 1;
            end
            5'b11101: e.res = a & ~(16'h1 << n);
            5'b11110: e.res = a | (16'h1 << n);
            default:  e.res = a;
        endcase
        e.z = (fs == 5'b11111) ? ~a[n] : (e.res == 0);
        return e;
    endfunction

    // Raise start for one cycle without touching the scoreboard.
    task automatic raw_start(input logic [4:0] fs, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        FS = fs; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 16'($urandom); B = 16'($urandom);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready && sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL idle_timeout: got ready=%b pending=%0d expected ready=1 pending=0",
                     ready, sb.size());
        end
    endtask

    task automatic apply_stimulus(input logic [4:0] fs, input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input bit wait_done);
        exp_t e;
        @(negedge clk);
        FS = fs; A = a; B = b; C_in = cin; start = 1'b1;
        e = model(fs, a, b, cin);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        A = 16'($urandom); B = 16'($urandom); C_in = 1'($urandom);
        if (wait_done) wait_idle();
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 expected done=0 (result=%h)", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("result", 32'(result), 32'(e.res));
                check_output("carry", 32'(C), 32'(e.c));
                check_output("zero", 32'(Z), 32'(e.z));
                check_output("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                check_output("busy_at_done", 32'(busy), 32'd1);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check_output("reset_ready", 32'(ready), 32'd1);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_result", 32'(result), 32'd0);
        check_output("reset_flags", 32'({C, Z}), 32'd0);
        reset = 1'b0;

        apply_stimulus(5'b11010, 16'h0003, 16'h0005, 1'b0, 1);
        apply_stimulus(5'b11010, 16'h0100, 16'h0100, 1'b0, 1);
        apply_stimulus(5'b11011, 16'hFFFF, 16'h0001, 1'b1, 1);
        apply_stimulus(5'b11100, 16'h8000, 16'h0004, 1'b0, 1);
        apply_stimulus(5'b11100, 16'h0009, 16'h0001, 1'b0, 1);
        apply_stimulus(5'b11100, 16'h8001, 16'h0000, 1'b0, 1);
        apply_stimulus(5'b11100, 16'h8001, 16'h000F, 1'b0, 1);
        apply_stimulus(5'b11110, 16'h0000, 16'h0003, 1'b0, 1);
        apply_stimulus(5'b11101, 16'h0008, 16'h0003, 1'b0, 1);
        apply_stimulus(5'b11111, 16'h0008, 16'h0003, 1'b0, 1);
        apply_stimulus(5'b11111, 16'h0008, 16'h0002, 1'b0, 1);

        // Non-SFU code: nothing may happen.
        raw_start(5'b00101, 16'h1234, 16'h0001);
        check_output("nonsfu_ready", 32'(ready), 32'd1);
        check_output("nonsfu_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);

        // Start during RUN is ignored; the first result must survive.
        apply_stimulus(5'b11010, 16'h0003, 16'h0005, 1'b0, 0);
        repeat (2) @(negedge clk);
        check_output("run_ready", 32'(ready), 32'd0);
        raw_start(5'b11010, 16'hFFFF, 16'hFFFF);
        wait_idle();
        repeat (20) @(negedge clk);

        // Reset in the middle of a multiply aborts it silently.
        raw_start(5'b11010, 16'h0007, 16'h0009);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("abort_ready", 32'(ready), 32'd1);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_result", 32'(result), 32'd0);
        check_output("abort_done", 32'(done), 32'd0);
        repeat (20) @(negedge clk);
        apply_stimulus(5'b11011, 16'h1234, 16'h4321, 1'b1, 1);

        for (int i = 0; i < 40; i++) begin
            apply_stimulus(5'($urandom_range(26, 31)), 16'($urandom), 16'($urandom),
                           1'($urandom), 1);
        end

        repeat (5) @(negedge clk);
        check_output("pending_at_end", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
